instr_predecode_queue: RTL and testbench
========================================

# instr_predecode_queue

Fetch-side buffer between instruction fetch and decode. Accepts 32-bit instructions with their PC, compresses each 7-bit RISC-V opcode into the 4-bit internal opcode class consumed by `instrdecoder`, and holds results in a small FIFO. Decode drains the FIFO through a valid/ready handshake. Flush support covers branch/jump redirects.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; power of two, at least 2.
- `CW`, $clog2(DEPTH)+1: width of `count`.

Ports:
- `clk` input 1: the single clock. All state updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `flush` input 1: synchronous discard of all entries (redirect).
- `in_valid` input 1: fetch presents an instruction.
- `in_ready` output 1: queue can accept an instruction this cycle.
- `in_instr` input 32: raw instruction.
- `in_pc` input 32: PC of `in_instr`.
- `out_valid` output 1: head entry is valid.
- `out_ready` input 1: decode consumes the head this cycle.
- `out_opcode` output 4: internal opcode class of the head entry.
- `out_illegal` output 1: head opcode is unrecognised.
- `out_instr` output 32: head raw instruction.
- `out_pc` output 32: head PC.
- `count` output CW: number of occupied entries.

## Operation
- Opcode classification uses `in_instr[6:0]`:
  - 0110011 → 0000 (R)
  - 0010011 → 0001 (I-ALU)
  - 0100011 → 0010 (S)
  - 1100011 → 0011 (B)
  - 0110111 → 0100 (LUI)
  - 1101111 → 0101 (JAL)
  - 0010111 → 0110 (AUIPC)
  - 1100111 → 0111 (JALR)
  - 0000011 → 1000 (Load)
  - Any other value, including bits[1:0] ≠ 11, → 1111 with illegal = 1.
- Classification happens at push. The class and illegal bit are stored with the instruction and PC.
- Push occurs when `in_valid && in_ready`. Pop occurs when `out_valid && out_ready`.
- `in_ready` = (count < DEPTH). It is not a function of `out_ready`, so no combinational path runs from `out_ready` to `in_ready`.
- `out_valid` = (count ≠ 0).
- When empty, outputs are forced to: `out_opcode` = 1111, `out_illegal` = 0, `out_instr` = 0, `out_pc` = 0.
- Storage is a circular buffer with read and write pointers of log2(DEPTH) bits. Pointers wrap from DEPTH−1 to 0.
- Push and pop in the same cycle, with count between 1 and DEPTH−1: both pointers advance and count is unchanged.
- Push while full: blocked, because `in_ready` = 0.
- Pop while empty: ignored, because `out_valid` = 0.
- Full with `out_ready` = 1: the pop happens and `in_ready` stays 0 that cycle. The freed slot becomes visible the next cycle.
- Flush or reset:
  - Pointers and count return to 0 on the next edge.
  - Flush wins over a simultaneous push and pop; neither takes effect.
  - Storage contents are not cleared.
- Reset mid-stream behaves identically to flush.

## Timing
- Reset values: count = 0, out_valid = 0, in_ready = 1, out_opcode = 1111, out_illegal = 0, out_instr = 0, out_pc = 0.
- Latency: an instruction pushed at edge N appears on `out_*` with `out_valid` = 1 after edge N (i.e. in cycle N+1). There is no same-cycle fall-through.
- Head outputs come from the registered storage through a read mux only. The classifier sits on the write path.
- Throughput: one push and one pop per cycle at steady state.
- `count` is registered and updated on the edge of each handshake.

## Structure
- Shared package `core_pkg`:
  - localparams for the nine 7-bit RISC-V opcodes.
  - enum `opclass_t` (4-bit) with the codes above plus `OPC_ILLEGAL` = 1111.
  - Shared with `instrdecoder` users.
- Sub-module `opcode_classify`:
  - Purely combinational.
  - Input: opcode[6:0]. Outputs: `opclass_t` and illegal.
  - Instantiated once on the push path.
- Top level holds the storage array, the pointers, the count and the handshake logic.

## Test plan
- Reset then single push of 0x00A00093 (ADDI) at PC 0x100 → next cycle out_valid = 1, out_opcode = 0001, out_pc = 0x100, out_illegal = 0; pop → out_valid = 0, out_opcode = 1111.
- Sweep all nine legal opcodes plus 0x0000007F and 0x00000000 → classes 0000…1000 in order, then 1111 with illegal = 1 for both.
- With DEPTH = 4 and out_ready = 0, push 5 instructions → in_ready drops after the 4th, count = 4, 5th held by fetch; one pop → in_ready = 1 next cycle, 5th accepted, FIFO order preserved.
- Continuous push and pop for 10 cycles across pointer wrap → count constant at 1, outputs in order, no drops.
- count = 3 with push, pop and flush asserted together → next cycle count = 0, out_valid = 0, in_ready = 1.
- Reset asserted with count = 2 → same as flush; all outputs return to reset values next cycle.

Source files
------------

// File: rtl/core_pkg.sv
// Shared opcode definitions for the fetch/predecode path and instrdecoder users.
// Holds the RISC-V major opcodes and the compressed 4-bit opcode class.
package core_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;

  typedef enum logic [3:0] {
    OPC_R       = 4'b0000,
    OPC_IALU    = 4'b0001,
    OPC_S       = 4'b0010,
    OPC_B       = 4'b0011,
    OPC_LUI     = 4'b0100,
    OPC_JAL     = 4'b0101,
    OPC_AUIPC   = 4'b0110,
    OPC_JALR    = 4'b0111,
    OPC_LOAD    = 4'b1000,
    OPC_ILLEGAL = 4'b1111
  } opclass_t;

endpackage

// File: rtl/opcode_classify.sv
// Combinational compression of a 7-bit RISC-V opcode into the internal opcode class.
// Anything outside the nine supported majors, including non-32-bit encodings, is illegal.
module opcode_classify
  import core_pkg::*;
(
  input  logic [6:0] opcode,
  output opclass_t   opclass,
  output logic       illegal
);

  always_comb begin
    opclass = OPC_ILLEGAL;
    case (opcode)
      OP_R:     opclass = OPC_R;
      OP_IALU:  opclass = OPC_IALU;
      OP_S:     opclass = OPC_S;
      OP_B:     opclass = OPC_B;
      OP_LUI:   opclass = OPC_LUI;
      OP_JAL:   opclass = OPC_JAL;
      OP_AUIPC: opclass = OPC_AUIPC;
      OP_JALR:  opclass = OPC_JALR;
      OP_LOAD:  opclass = OPC_LOAD;
      default:  opclass = OPC_ILLEGAL;
    endcase
    illegal = (opclass == OPC_ILLEGAL);
  end

endmodule

// File: rtl/instr_predecode_queue.sv
// Fetch-to-decode FIFO that classifies each instruction's opcode on the way in.
// Head outputs come straight from registered storage; flush/reset drop all entries.
module instr_predecode_queue
  import core_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_instr,
  input  logic [31:0]   in_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [3:0]    out_opcode,
  output logic          out_illegal,
  output logic [31:0]   out_instr,
  output logic [31:0]   out_pc,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [31:0]      mem_instr [DEPTH];
  logic [31:0]      mem_pc    [DEPTH];
  opclass_t         mem_class [DEPTH];
  logic [DEPTH-1:0] mem_ill;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          clear;
  opclass_t      in_class;
  logic          in_illegal;

  opcode_classify u_classify (
    .opcode  (in_instr[6:0]),
    .opclass (in_class),
    .illegal (in_illegal)
  );

  // in_ready depends on count only, keeping out_ready off the fetch-side timing path
  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign clear     = reset || flush;

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is left uncleared on flush; the pointers alone define occupancy
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem_instr[wr_ptr] <= in_instr;
      mem_pc[wr_ptr]    <= in_pc;
      mem_class[wr_ptr] <= in_class;
      mem_ill[wr_ptr]   <= in_illegal;
    end
  end

  always_comb begin
    out_opcode  = OPC_ILLEGAL;
    out_illegal = 1'b0;
    out_instr   = '0;
    out_pc      = '0;
    if (out_valid) begin
      out_opcode  = mem_class[rd_ptr];
      out_illegal = mem_ill[rd_ptr];
      out_instr   = mem_instr[rd_ptr];
      out_pc      = mem_pc[rd_ptr];
    end
  end

endmodule

// File: tb/tb_instr_predecode_queue.sv
// Directed bench for instr_predecode_queue (DEPTH = 4): reset, classification,
// backpressure, streaming across pointer wrap, flush and mid-stream reset.
module tb_instr_predecode_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_opcode;
  logic        out_illegal;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  instr_predecode_queue #(.DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_opcode  (out_opcode),
    .out_illegal (out_illegal),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .count       (count)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_opcode !== 4'hF) begin errors++; $display("FAIL reset_opcode got %h want f", out_opcode); end
    checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b want 0", out_illegal); end
    checks++; if (out_instr !== 32'h0 || out_pc !== 32'h0) begin errors++; $display("FAIL reset_data got instr %h pc %h want 0 0", out_instr, out_pc); end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_instr = 32'h00A00093; in_pc = 32'h100;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_no_fallthrough got %b want 0", out_valid); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", out_valid); end
    checks++; if (out_opcode !== 4'b0001) begin errors++; $display("FAIL single_opcode got %b want 0001", out_opcode); end
    checks++; if (out_pc !== 32'h100) begin errors++; $display("FAIL single_pc got %h want 100", out_pc); end
    checks++; if (out_instr !== 32'h00A00093) begin errors++; $display("FAIL single_instr got %h want 00a00093", out_instr); end
    checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL single_illegal got %b want 0", out_illegal); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got %0d want 1", count); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid got %b want 0", out_valid); end
    checks++; if (out_opcode !== 4'hF) begin errors++; $display("FAIL single_pop_opcode got %h want f", out_opcode); end
  endtask

  task automatic test_classify();
    logic [6:0] ops [11];
    logic [3:0] cls [11];
    logic       ill [11];
    logic [31:0] w;
    ops = '{7'b0110011, 7'b0010011, 7'b0100011, 7'b1100011, 7'b0110111, 7'b1101111,
            7'b0010111, 7'b1100111, 7'b0000011, 7'h7F, 7'h00};
    cls = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hF, 4'hF};
    ill = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 11; i++) begin
      w = (i == 10) ? 32'h0 : {25'h0ABCDE, ops[i]};
      in_valid = 1'b1; in_instr = w; in_pc = 32'h1000 + 32'(4 * i);
      step();
      in_valid = 1'b0;
      checks++; if (out_opcode !== cls[i] || out_illegal !== ill[i])
        begin errors++; $display("FAIL classify_%0d got class %b ill %b want class %b ill %b", i, out_opcode, out_illegal, cls[i], ill[i]); end
      checks++; if (out_instr !== w) begin errors++; $display("FAIL classify_instr_%0d got %h want %h", i, out_instr, w); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_instr = 32'h00000013 | (32'(i) << 20); in_pc = 32'h200 + 32'(4 * i);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_%0d got %b want 1", i, in_ready); end
      step();
    end
    in_instr = 32'h00400013; in_pc = 32'h210;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b want 0", in_ready); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL bp_full_count got %0d want 4", count); end
    step();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL bp_held_count got %0d want 4", count); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (count !== 3'd3 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_after_pop got count %0d ready %b want 3 1", count, in_ready); end
    checks++; if (out_pc !== 32'h204) begin errors++; $display("FAIL bp_head_pc got %h want 204", out_pc); end
    step();
    in_valid = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL bp_fifth_count got %0d want 4", count); end
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checks++; if (out_pc !== 32'h200 + 32'(4 * k) || out_instr !== (32'h00000013 | (32'(k) << 20)))
        begin errors++; $display("FAIL bp_order_%0d got pc %h instr %h want pc %h", k, out_pc, out_instr, 32'h200 + 32'(4 * k)); end
      step();
    end
    out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL bp_drained got %0d want 0", count); end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_instr = 32'h00000033; in_pc = 32'h300;
    step();
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      in_instr = 32'h00000033 | (32'(i) << 7); in_pc = 32'h300 + 32'(4 * i);
      checks++; if (out_pc !== 32'h300 + 32'(4 * (i - 1))) begin errors++; $display("FAIL b2b_head_%0d got %h want %h", i, out_pc, 32'h300 + 32'(4 * (i - 1))); end
      step();
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL b2b_count_%0d got %0d want 1", i, count); end
    end
    in_valid = 1'b0;
    checks++; if (out_instr !== (32'h00000033 | (32'd10 << 7)) || out_opcode !== 4'h0)
      begin errors++; $display("FAIL b2b_last got instr %h class %b want %h 0000", out_instr, out_opcode, 32'h00000033 | (32'd10 << 7)); end
    step();
    out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL b2b_drained got %0d want 0", count); end
  endtask

  task automatic test_flush();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_instr = 32'h00000063; in_pc = 32'h400 + 32'(4 * i);
      step();
    end
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre_count got %0d want 3", count); end
    out_ready = 1'b1; flush = 1'b1; in_pc = 32'h40C;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL flush_state got count %0d valid %b ready %b want 0 0 1", count, out_valid, in_ready); end
    in_valid = 1'b1; in_instr = 32'h00000017; in_pc = 32'h500;
    step();
    in_valid = 1'b0;
    checks++; if (out_pc !== 32'h500 || out_opcode !== 4'h6) begin errors++; $display("FAIL flush_refill got pc %h class %b want 500 0110", out_pc, out_opcode); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_instr = 32'h00000003;
    for (int i = 0; i < 2; i++) begin
      in_pc = 32'h600 + 32'(4 * i);
      step();
    end
    in_valid = 1'b0;
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL rmid_pre_count got %0d want 2", count); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL rmid_state got count %0d valid %b ready %b want 0 0 1", count, out_valid, in_ready); end
    checks++; if (out_opcode !== 4'hF || out_illegal !== 1'b0 || out_instr !== 32'h0 || out_pc !== 32'h0)
      begin errors++; $display("FAIL rmid_outputs got %h %b %h %h want f 0 0 0", out_opcode, out_illegal, out_instr, out_pc); end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    test_reset();
    test_single();
    test_classify();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
